ex_stage_mc: RTL and testbench

//  Parametrised execute stage for the 5-stage RISCV core; sits between ID/EX and EX/MEM.
//  - Resolves operand forwarding (EX/MEM, WB) and executes single-cycle ALU ops.
//  - Optionally runs an iterative multiply/divide unit.
//  - Holds its own EX/MEM output register under a valid/ready handshake, so a

---
 rtl/ex_stage_mc.sv | 209 ++++++++++++++++++++
 tb/tb_ex_stage_mc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: RV execute stage with operand forwarding, single-cycle ALU and a handshaked EX/MEM register.
// Define EX_MULDIV_EN to build the iterative multiply/divide unit; without it ops 10-15 raise out_illegal.
module ex_stage_mc #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PT_W = 48
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [1:0]      fa_sel,
    input  logic [1:0]      fb_sel,
    input  logic [XLEN-1:0] fw_wb_data,
    input  logic [PT_W-1:0] in_pt,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [PT_W-1:0] out_pt,
    output logic            out_illegal
);
    localparam int unsigned SH_W  = $clog2(XLEN);
    localparam int unsigned CNT_W = $clog2(XLEN);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic [PT_W-1:0] out_pt_q, out_pt_d;
    logic            out_illegal_q, out_illegal_d;

    logic            accept, is_md_op, md_start, md_done, illegal_op;
    logic [XLEN-1:0] op_a, op_b, alu_res, md_res;
    logic [PT_W-1:0] md_pt;
    logic [SH_W-1:0] shamt;

    assign is_md_op = (in_op >= 4'd10);
    assign in_ready = !reset && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // Sel 1 forwards whatever the output register currently holds, valid or not.
    always_comb begin
        case (fa_sel)
            2'd1:    op_a = out_result_q;
            2'd2:    op_a = fw_wb_data;
            default: op_a = in_a;
        endcase
        case (fb_sel)
            2'd1:    op_b = out_result_q;
            2'd2:    op_b = fw_wb_data;
            default: op_b = in_b;
        endcase
    end

    always_comb begin
        shamt   = op_b[SH_W-1:0];
        alu_res = '0;
        case (in_op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = op_a << shamt;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $signed(op_a) >>> shamt;
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step, mul_full;
    logic [XLEN-1:0]   opnd_q, opnd_d, a_mag, b_mag, step_lo, step_hi;
    logic [2:0]        md_op_q, md_op_d;
    logic              neg_q, neg_d, bz_q, bz_d;
    logic [PT_W-1:0]   md_pt_q, md_pt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              md_signed, a_neg, b_neg;
    logic [XLEN:0]     mul_sum, div_rsh, div_diff;

    assign md_start   = accept && is_md_op;
    assign md_done    = (state_q == BUSY) && (cnt_q == CNT_W'(XLEN-1)) && !flush;
    assign illegal_op = 1'b0;
    assign md_pt      = md_pt_q;

    // acc holds {hi, lo}: MUL = {partial product, multiplier}, DIV = {remainder, dividend/quotient}.
    always_comb begin
        md_signed = !(in_op[2] && in_op[0]);
        a_neg     = md_signed && op_a[XLEN-1];
        b_neg     = md_signed && op_b[XLEN-1];
        a_mag     = a_neg ? -op_a : op_a;
        b_mag     = b_neg ? -op_b : op_b;

        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_rsh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_rsh - {1'b0, opnd_q};
        if (!md_op_q[2])
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        else if (div_diff[XLEN])
            acc_step = {div_rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        acc_d   = acc_q;
        opnd_d  = opnd_q;
        md_op_d = md_op_q;
        neg_d   = neg_q;
        bz_d    = bz_q;
        md_pt_d = md_pt_q;
        cnt_d   = cnt_q;
        if (md_start) begin
            md_op_d = in_op[2:0];
            acc_d   = {{XLEN{1'b0}}, in_op[2] ? a_mag : b_mag};
            opnd_d  = in_op[2] ? b_mag : a_mag;
            neg_d   = (in_op[2] && in_op[1]) ? a_neg : (a_neg ^ b_neg);
            bz_d    = (op_b == '0);
            md_pt_d = in_pt;
            cnt_d   = '0;
        end else if (state_q == BUSY) begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
        end

        mul_full = neg_q ? -acc_step : acc_step;
        step_lo  = acc_step[XLEN-1:0];
        step_hi  = acc_step[2*XLEN-1:XLEN];
        if (!md_op_q[2])
            md_res = md_op_q[0] ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
        else if (md_op_q[1])
            md_res = neg_q ? -step_hi : step_hi;
        else if (bz_q)
            md_res = '1;
        else
            md_res = neg_q ? -step_lo : step_lo;
    end

    always_ff @(posedge clock) begin
        acc_q   <= acc_d;
        opnd_q  <= opnd_d;
        md_op_q <= md_op_d;
        neg_q   <= neg_d;
        bz_q    <= bz_d;
        md_pt_q <= md_pt_d;
        cnt_q   <= cnt_d;
    end
`else
    assign md_start   = 1'b0;
    assign md_done    = 1'b0;
    assign md_res     = '0;
    assign md_pt      = '0;
    assign illegal_op = is_md_op;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (md_start) state_d = BUSY;
            BUSY:    if (flush || md_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_pt_d      = out_pt_q;
        out_illegal_d = out_illegal_q;
        if (accept && !md_start) begin
            out_valid_d   = 1'b1;
            out_result_d  = illegal_op ? '0 : alu_res;
            out_pt_d      = in_pt;
            out_illegal_d = illegal_op;
        end else if (md_done) begin
            out_valid_d   = 1'b1;
            out_result_d  = md_res;
            out_pt_d      = md_pt;
            out_illegal_d = 1'b0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_pt_q      <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_pt_q      <= out_pt_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_pt      = out_pt_q;
    assign out_illegal = out_illegal_q;
endmodule

// File: tb/tb_ex_stage_mc.sv
// Bench for ex_stage_mc: directed scenarios plus random traffic checked every cycle against a transaction model.
module tb_ex_stage_mc;
    localparam int unsigned XLEN = 32;
    localparam int unsigned PT_W = 48;
`ifdef EX_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic            clock, reset, in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_a, in_b, fw_wb_data, out_result;
    logic [1:0]      fa_sel, fb_sel;
    logic [PT_W-1:0] in_pt, out_pt;

    ex_stage_mc #(.XLEN(XLEN), .PT_W(PT_W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .fa_sel(fa_sel), .fb_sel(fb_sel),
        .fw_wb_data(fw_wb_data), .in_pt(in_pt), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_pt(out_pt), .out_illegal(out_illegal)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic signed [31:0] t;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << b[4:0];
            4'd6:  return a >> b[4:0];
            4'd7:  begin t = $signed(a) >>> b[4:0]; return t; end
            4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [32:0] model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 4'd10 && !MD_EN) return {1'b1, 32'h0};
        return {1'b0, ref_op(op, a, b)};
    endfunction

    // Model state describes what the DUT should show in the current cycle.
    logic            m_valid = 1'b0, m_illegal = 1'b0;
    logic [31:0]     m_result = '0, m_pend_res = '0;
    logic [PT_W-1:0] m_pt = '0, m_pend_pt = '0;
    int              m_busy = 0;
    bit              m_live = 1'b0;

    initial begin
        logic        exp_ready, take, load;
        logic [31:0] a, b;
        logic [32:0] r;
        forever begin
            @(negedge clock);
            exp_ready = !reset && m_busy == 0 && (!m_valid || out_ready);
            if (m_live) begin
                check("in_ready", in_ready, exp_ready);
                check("out_valid", out_valid, m_valid);
                check("out_result", out_result, m_result);
                check("out_pt", out_pt, m_pt);
                check("out_illegal", out_illegal, m_illegal);
            end
            if (reset) begin
                m_valid = 0; m_illegal = 0; m_result = '0; m_pt = '0; m_busy = 0; m_live = 1;
            end else begin
                a = (fa_sel == 2'd1) ? m_result : (fa_sel == 2'd2) ? fw_wb_data : in_a;
                b = (fb_sel == 2'd1) ? m_result : (fb_sel == 2'd2) ? fw_wb_data : in_b;
                take = in_valid && exp_ready && !flush;
                load = 0;
                if (m_busy > 0) begin
                    if (flush) m_busy = 0;
                    else if (m_busy == 1) begin
                        m_busy = 0; load = 1;
                        r = {1'b0, m_pend_res};
                        a = '0;
                    end else m_busy--;
                    if (load) begin
                        m_valid = 1; m_result = m_pend_res; m_pt = m_pend_pt; m_illegal = 0;
                    end
                end else if (take) begin
                    r = model_exec(in_op, a, b);
                    if (MD_EN && in_op >= 4'd10) begin
                        m_busy = XLEN; m_pend_res = r[31:0]; m_pend_pt = in_pt;
                    end else begin
                        load = 1; m_valid = 1; m_result = r[31:0]; m_pt = in_pt; m_illegal = r[32];
                    end
                end
                if (!load && out_ready) m_valid = 0;
            end
        end
    end

    task automatic drive(input bit rst, input bit v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] wb, input bit fl, input bit ordy);
        @(posedge clock);
        #1;
        reset = rst; in_valid = v; in_op = op; in_a = a; in_b = b; fa_sel = fa; fb_sel = fb;
        fw_wb_data = wb; flush = fl; out_ready = ordy;
        in_pt = {16'($urandom()), $urandom()};
    endtask

    task automatic idle(input int n, input bit ordy);
        repeat (n) drive(0, 0, 4'd0, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 0, ordy);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [3:0] op;
        reset = 1; in_valid = 0; in_op = '0; in_a = '0; in_b = '0; fa_sel = '0; fb_sel = '0;
        fw_wb_data = '0; flush = 0; out_ready = 0; in_pt = '0;

        check("pin_add", ref_op(4'd0, 32'd5, 32'd7), 32'd12);
        check("pin_div_ovf", ref_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("pin_rem_dz", ref_op(4'd14, 32'd7, 32'd0), 32'd7);
        check("pin_divu_dz", ref_op(4'd13, 32'd7, 32'd0), 32'hFFFF_FFFF);
        check("pin_div_dz_neg", ref_op(4'd12, 32'hFFFF_FFF9, 32'd0), 32'hFFFF_FFFF);
        check("pin_mulh", ref_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'd0);
        check("pin_mul", ref_op(4'd10, 32'h1_0000, 32'h1_0000), 32'd0);
        check("pin_sra", ref_op(4'd7, 32'h8000_0000, 32'd36), 32'hF800_0000);
        check("pin_slt", ref_op(4'd8, 32'hFFFF_FFFF, 32'd1), 32'd1);
        check("pin_rem_neg", ref_op(4'd14, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        repeat (3) drive(1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1);
        // T1/T2: ADD, then SUB forwarding EX/MEM, then ADD forwarding WB
        drive(0, 1, 4'd0, 32'd5, 32'd7, 2'd0, 2'd0, 32'd0, 0, 1);
        drive(0, 1, 4'd1, 32'd99, 32'd2, 2'd1, 2'd0, 32'd0, 0, 1);
        @(negedge clock);
        check("t1_add", {out_valid, out_result}, {1'b1, 32'd12});
        drive(0, 1, 4'd0, 32'd3, 32'd50, 2'd0, 2'd2, 32'd9, 0, 1);
        @(negedge clock);
        check("t2_sub_fwd", {out_valid, out_result}, {1'b1, 32'd10});
        idle(1, 1);
        @(negedge clock);
        check("t2_add_wb", {out_valid, out_result}, {1'b1, 32'd12});
        // T3/T4: mul/div corner cases, in_valid held during BUSY
        drive(0, 1, 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
        repeat (34) drive(0, 1, 4'd0, 32'd1, 32'd1, 0, 0, 0, 0, 1);
        drive(0, 1, 4'd14, 32'd7, 32'd0, 0, 0, 0, 0, 1);
        idle(34, 1);
        drive(0, 1, 4'd13, 32'd7, 32'd0, 0, 0, 0, 0, 1);
        idle(34, 1);
        drive(0, 1, 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
        idle(34, 1);
        drive(0, 1, 4'd10, 32'h1_0000, 32'h1_0000, 0, 0, 0, 0, 1);
        idle(34, 1);
        // T5: output back-pressure, then consume and accept in the same cycle
        drive(0, 1, 4'd4, 32'hA5A5_0000, 32'h0000_5A5A, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 1, 4'd3, 32'h1, 32'h2, 0, 0, 0, 0, 0);
        drive(0, 1, 4'd3, 32'h10, 32'h2, 0, 0, 0, 0, 1);
        idle(2, 1);
        // T6: flush on the tenth BUSY cycle
        drive(0, 1, 4'd12, 32'd100, 32'd7, 0, 0, 0, 0, 1);
        idle(9, 1);
        drive(0, 0, 4'd0, 0, 0, 0, 0, 0, 1, 1);
        idle(40, 1);

        for (int i = 0; i < 3000; i++) begin
            op = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, op, pick(), pick(),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pick(),
                  $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
        end
        idle(40, 1);
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
